riscv_regfile_mp: RTL

- Parametrised multi-port integer register file for the RISC-V core; next generation of the single-write, two-read regfile.
- Adds a configurable number of read and write ports, width and depth, optional write-to-read bypass, and a per-register pending-write scoreboard.
- Sits between decode (operand read, destination reservation) and write-back (result commit).

---
 rtl/riscv_regfile_mp_pkg.sv | 19 +
 rtl/riscv_regfile_mp_scoreboard.sv | 69 ++++++
 rtl/riscv_regfile_mp.sv | 97 +++++++++
 3 files changed

// File: rtl/riscv_regfile_mp_pkg.sv
// Shared definitions for the multi-port integer register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default data width and register count, address/data types for
// the default configuration, and the index of the hard-wired zero register.
package riscv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    // Index of the architectural zero register (x0).
    localparam int REG_ZERO = 0;

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xlen_t;

endpackage

// File: rtl/riscv_regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reservation, cleared by write.
// Latency: set/clear visible one cycle after the edge; per-port lookup is combinational.
// Backpressure: none; the caller applies hazard policy using the busy bits.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), async active-low reset
//   wen_i, waddr_i       write-back enables/addresses (clear busy)
//   resv_en_i, resv_addr_i  destination reservation (set busy)
//   raddr_i / busy_r_o   per-read-port busy lookup from registered state
//   busy_o               full busy vector
module riscv_regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NRP      = 2,
    parameter int NWP      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NWP-1:0]          wen_i,
    input  logic [NWP-1:0][AW-1:0]  waddr_i,
    input  logic                    resv_en_i,
    input  logic [AW-1:0]           resv_addr_i,
    input  logic [NRP-1:0][AW-1:0]  raddr_i,
    output logic [NRP-1:0]          busy_r_o,
    output logic [NREGS-1:0]        busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears first, then the set: a reservation landing on the register
    // being written means a newer producer was issued, so it must stay busy.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWP; k++) begin
            if (wen_i[k]) begin
                busy_d[waddr_i[k]] = 1'b0;
            end
        end
        if (resv_en_i) begin
            busy_d[resv_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[REG_ZERO] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Lookup is from registered state only; no forwarding of the clear.
    always_comb begin
        busy_r_o = '0;
        for (int p = 0; p < NRP; p++) begin
            busy_r_o[p] = busy_q[raddr_i[p]];
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and pending-write scoreboard.
// Latency: reads combinational (0 cycles); writes visible after the clock edge (same cycle with bypass).
// Backpressure: none; no handshake, hazards are resolved by the caller via BusyR_o / Busy_o.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), async active-low reset
//   AddrR_i / DataR_o / BusyR_o  per-read-port address, data, busy bit
//   WEn_i / AddrW_i / DataW_i    per-write-port enable, address, data
//   ResvEn_i / ResvAddr_i        destination reservation
//   Busy_o                       full scoreboard vector
module riscv_regfile_mp
    import riscv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NRP      = 2,
    parameter int NWP      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NRP-1:0][AW-1:0]   AddrR_i,
    output logic [NRP-1:0][XLEN-1:0] DataR_o,
    output logic [NRP-1:0]           BusyR_o,
    input  logic [NWP-1:0]           WEn_i,
    input  logic [NWP-1:0][AW-1:0]   AddrW_i,
    input  logic [NWP-1:0][XLEN-1:0] DataW_i,
    input  logic                     ResvEn_i,
    input  logic [AW-1:0]            ResvAddr_i,
    output logic [NREGS-1:0]         Busy_o
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0][XLEN-1:0] regs_d;

    // Ports are applied in ascending order so the highest-index port
    // overwrites lower ones when several target the same register.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NWP; k++) begin
            if (WEn_i[k] && !((ZERO_REG != 0) && (AddrW_i[k] == ZERO_ADDR))) begin
                regs_d[AddrW_i[k]] = DataW_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read mux. Bypass scans write ports in ascending order, matching the
    // write priority. Bypass is suppressed while in reset so every address
    // reads 0 even if a write is being presented. The zero-register override
    // comes last so it also masks bypassed data.
    always_comb begin
        DataR_o = '0;
        for (int p = 0; p < NRP; p++) begin
            DataR_o[p] = regs_q[AddrR_i[p]];
            if ((BYPASS != 0) && rst_i) begin
                for (int k = 0; k < NWP; k++) begin
                    if (WEn_i[k] && (AddrW_i[k] == AddrR_i[p])) begin
                        DataR_o[p] = DataW_i[k];
                    end
                end
            end
            if ((ZERO_REG != 0) && (AddrR_i[p] == ZERO_ADDR)) begin
                DataR_o[p] = '0;
            end
        end
    end

    riscv_regfile_scoreboard #(
        .NREGS    (NREGS),
        .NRP      (NRP),
        .NWP      (NWP),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wen_i       (WEn_i),
        .waddr_i     (AddrW_i),
        .resv_en_i   (ResvEn_i),
        .resv_addr_i (ResvAddr_i),
        .raddr_i     (AddrR_i),
        .busy_r_o    (BusyR_o),
        .busy_o      (Busy_o)
    );

endmodule
